inv_key_schedule: RTL and testbench

INV_KEY_SCHEDULE -- requirements
Module: inv_key_schedule

---
 rtl/aes_pkg.sv | 62 ++++++
 rtl/sbox.sv | 29 ++
 rtl/inv_key_schedule.sv | 123 ++++++++++++
 tb/tb_inv_key_schedule.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) helpers.
// InvMixColumns helper exists only when INV_KS_EQ_INV_CIPHER_EN is defined.
package aes_pkg;

    localparam int AES_ROUNDS = 10;

    typedef enum logic [2:0] {
        IDLE,
        EMIT,
        XOR3,
        XOR2,
        XOR1,
        SUB,
        XOR0
    } ks_state_t;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

`ifdef INV_KS_EQ_INV_CIPHER_EN
    function automatic logic [31:0] inv_mix_word(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction
`endif

endpackage

// File: rtl/sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    logic [7:0] sq;
    logic [7:0] inv;

    // x^254 = product of x^(2^k) for k=1..7; maps 0 to 0 as the S-box requires.
    always_comb begin
        sq  = in_byte;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
    end

    assign out_byte = inv
                    ^ {inv[6:0], inv[7]}
                    ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]}
                    ^ 8'h63;

endmodule

// File: rtl/inv_key_schedule.sv
// Reverse AES-128 key schedule: emits round keys 10..0 from the round-10 key.
// Define INV_KS_EQ_INV_CIPHER_EN to apply InvMixColumns to output rounds 9..1.
module inv_key_schedule
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] last_key,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy,
    output logic         done
);

    // Handshake: a round key transfers on a rising edge where rk_valid and
    // rk_ready are both high; round_key/round_idx hold until that edge.

    ks_state_t    state;
    logic [127:0] key_q;
    logic [31:0]  new3_q, new2_q, new1_q;
    logic [31:0]  rot_q, sub_q;
    logic [3:0]   idx_q;
    logic         valid_q, busy_q, done_q;

    logic [31:0]  k0, k1, k2, k3;
    logic [31:0]  new3_w;
    logic [31:0]  sub_w;

    assign {k0, k1, k2, k3} = key_q;
    assign new3_w = k3 ^ k2;

    genvar g;
    for (g = 0; g < 4; g++) begin : g_sbox
        sbox u_sbox (
            .in_byte  (rot_q[8*g +: 8]),
            .out_byte (sub_w[8*g +: 8])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            key_q   <= '0;
            new3_q  <= '0;
            new2_q  <= '0;
            new1_q  <= '0;
            rot_q   <= '0;
            sub_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        key_q   <= last_key;
                        idx_q   <= 4'(AES_ROUNDS);
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        state   <= EMIT;
                    end
                end
                EMIT: begin
                    if (rk_ready) begin
                        valid_q <= 1'b0;
                        if (idx_q == 4'd0) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            state <= XOR3;
                        end
                    end
                end
                XOR3: begin
                    new3_q <= new3_w;
                    rot_q  <= {new3_w[23:0], new3_w[31:24]};
                    state  <= XOR2;
                end
                XOR2: begin
                    new2_q <= k2 ^ k1;
                    state  <= XOR1;
                end
                XOR1: begin
                    new1_q <= k1 ^ k0;
                    state  <= SUB;
                end
                SUB: begin
                    sub_q <= sub_w;
                    state <= XOR0;
                end
                XOR0: begin
                    key_q   <= {k0 ^ sub_q ^ {rcon(idx_q), 24'h0}, new1_q, new2_q, new3_q};
                    idx_q   <= idx_q - 4'd1;
                    valid_q <= 1'b1;
                    state   <= EMIT;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef INV_KS_EQ_INV_CIPHER_EN
    // Key register stays in plain form; only the outgoing inner rounds are mixed.
    logic mix_en;
    assign mix_en    = (idx_q != 4'd0) && (idx_q != 4'(AES_ROUNDS));
    assign round_key = mix_en ? {inv_mix_word(k0), inv_mix_word(k1),
                                 inv_mix_word(k2), inv_mix_word(k3)} : key_q;
`else
    assign round_key = key_q;
`endif

    assign round_idx = idx_q;
    assign rk_valid  = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for inv_key_schedule using the FIPS-197 Appendix A.1 key expansion.
`timescale 1ns/1ps
module tb_inv_key_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] last_key;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    localparam logic [127:0] K10     = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K_OTHER = 128'h000102030405060708090a0b0c0d0e0f;

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    inv_key_schedule dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .last_key  (last_key),
        .round_key (round_key),
        .round_idx (round_idx),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .busy      (busy),
        .done      (done)
    );

    function automatic logic [127:0] fips_rk(input int r);
        logic [127:0] k;
        case (r)
            0:       k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
            1:       k = 128'ha0fafe1788542cb123a339392a6c7605;
            2:       k = 128'hf2c295f27a96b9435935807a7359f67f;
            3:       k = 128'h3d80477d4716fe3e1e237e446d7a883b;
            4:       k = 128'hef44a541a8525b7fb671253bdb0bad00;
            5:       k = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
            6:       k = 128'h6d88a37a110b3efddbf98641ca0093fd;
            7:       k = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
            8:       k = 128'head27321b58dbad2312bf5607f8d292f;
            9:       k = 128'hac7766f319fadc2128d12941575c006e;
            default: k = K10;
        endcase
        return k;
    endfunction

`ifdef INV_KS_EQ_INV_CIPHER_EN
    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [31:0] tb_imc(input logic [31:0] w);
        logic [7:0] b [4];
        logic [7:0] o [4];
        logic [7:0] m [4];
        m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        for (int i = 0; i < 4; i++) b[i] = w[31-8*i -: 8];
        for (int row = 0; row < 4; row++) begin
            o[row] = 8'h00;
            for (int col = 0; col < 4; col++)
                o[row] = o[row] ^ tb_mul(b[col], m[(col - row + 4) % 4]);
        end
        return {o[0], o[1], o[2], o[3]};
    endfunction
`endif

    function automatic logic [127:0] exp_rk(input int r);
        logic [127:0] k;
        k = fips_rk(r);
`ifdef INV_KS_EQ_INV_CIPHER_EN
        if (r >= 1 && r <= 9)
            k = {tb_imc(k[127:96]), tb_imc(k[95:64]), tb_imc(k[63:32]), tb_imc(k[31:0])};
`endif
        return k;
    endfunction

    // Driver: called just after a falling edge; returns just after the next one.
    task automatic start_pulse(input logic [127:0] k);
        start    = 1'b1;
        last_key = k;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_valid(output int lows, output bit timed_out);
        lows      = 0;
        timed_out = 1'b0;
        while (rk_valid !== 1'b1) begin
            if (lows >= 50) begin
                timed_out = 1'b1;
                return;
            end
            @(negedge clk);
            lows++;
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b1;
        last_key = K10;
        rk_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            round_idx !== 4'd0 || round_key !== 128'h0) begin
            errors++;
            $display("FAIL reset_state: valid=%b busy=%b done=%b idx=%0d key=%h, required 0 0 0 0 0",
                     rk_valid, busy, done, round_idx, round_key);
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_with_rst_ignored: valid=%b busy=%b, required 0 0", rk_valid, busy);
        end
    endtask

    task automatic test_fips_vector();
        logic [127:0] exp_q[$];
        logic [127:0] exp;
        int lows;
        bit to;
        int done_before;
        for (int r = 10; r >= 0; r--) exp_q.push_back(exp_rk(r));
        done_before = done_cnt;
        rk_ready = 1'b1;
        start_pulse(K10);
        checks++;
        if (rk_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: valid=%b busy=%b one cycle after start, required 1 1", rk_valid, busy);
        end
        for (int r = 10; r >= 0; r--) begin
            wait_valid(lows, to);
            if (r != 10) begin
                checks++;
                if (to || lows != 5) begin
                    errors++;
                    $display("FAIL accept_latency r=%0d: %0d low cycles (timeout=%b), required 5", r, lows, to);
                end
            end
            exp = exp_q.pop_front();
            checks++;
            if (round_idx !== 4'(r) || round_key !== exp || done !== 1'b0) begin
                errors++;
                $display("FAIL fips_round r=%0d: idx=%0d key=%h done=%b, required idx=%0d key=%h done=0",
                         r, round_idx, round_key, done, r, exp);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || rk_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b busy=%b valid=%b, required 1 0 0", done, busy, rk_valid);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b0 || done_cnt - done_before != 1) begin
            errors++;
            $display("FAIL done_once: done=%b pulses=%0d, required 0 and 1 pulse", done, done_cnt - done_before);
        end
    endtask

    task automatic test_backpressure();
        int lows;
        bit to;
        rk_ready = 1'b1;
        start_pulse(K10);
        for (int r = 10; r >= 0; r--) begin
            wait_valid(lows, to);
            checks++;
            if (to || round_idx !== 4'(r) || round_key !== exp_rk(r)) begin
                errors++;
                $display("FAIL bp_round r=%0d: idx=%0d key=%h timeout=%b, required idx=%0d key=%h",
                         r, round_idx, round_key, to, r, exp_rk(r));
            end
            if (r == 5) begin
                rk_ready = 1'b0;
                for (int c = 0; c < 7; c++) begin
                    @(negedge clk);
                    checks++;
                    if (rk_valid !== 1'b1 || round_idx !== 4'd5 || round_key !== exp_rk(5)) begin
                        errors++;
                        $display("FAIL bp_hold c=%0d: valid=%b idx=%0d key=%h, required 1 5 %h",
                                 c, rk_valid, round_idx, round_key, exp_rk(5));
                    end
                end
                rk_ready = 1'b1;
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_done: done=%b busy=%b, required 1 0", done, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int lows;
        bit to;
        rk_ready = 1'b1;
        start_pulse(K10);
        for (int r = 10; r >= 6; r--) begin
            wait_valid(lows, to);
            checks++;
            if (to || round_idx !== 4'(r) || round_key !== exp_rk(r)) begin
                errors++;
                $display("FAIL mr_round r=%0d: idx=%0d key=%h, required idx=%0d key=%h",
                         r, round_idx, round_key, r, exp_rk(r));
            end
            @(negedge clk);
        end
        // Now in XOR3 after accepting round 6; three more edges reach SUB.
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            round_idx !== 4'd0 || round_key !== 128'h0) begin
            errors++;
            $display("FAIL mr_reset: valid=%b busy=%b done=%b idx=%0d key=%h, required 0 0 0 0 0",
                     rk_valid, busy, done, round_idx, round_key);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mr_abandoned: valid=%b busy=%b, required 0 0", rk_valid, busy);
        end
        rk_ready = 1'b0;
        start_pulse(K10);
        checks++;
        if (rk_valid !== 1'b1 || round_idx !== 4'd10 || round_key !== K10) begin
            errors++;
            $display("FAIL mr_restart: valid=%b idx=%0d key=%h, required 1 10 %h",
                     rk_valid, round_idx, round_key, K10);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_start_while_busy();
        int lows;
        bit to;
        rk_ready = 1'b1;
        start_pulse(K10);
        checks++;
        if (rk_valid !== 1'b1 || round_key !== K10) begin
            errors++;
            $display("FAIL swb_first: valid=%b key=%h, required 1 %h", rk_valid, round_key, K10);
        end
        @(negedge clk);
        @(negedge clk);
        start_pulse(K_OTHER);
        last_key = K10;
        for (int r = 9; r >= 0; r--) begin
            wait_valid(lows, to);
            checks++;
            if (to || round_idx !== 4'(r) || round_key !== exp_rk(r)) begin
                errors++;
                $display("FAIL swb_round r=%0d: idx=%0d key=%h, required idx=%0d key=%h",
                         r, round_idx, round_key, r, exp_rk(r));
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL swb_done: done=%b busy=%b, required 1 0", done, busy);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fips_vector();
        test_backpressure();
        test_mid_reset();
        test_start_while_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
